// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the NanoProcessor fetch sequencer: FSM state encodings
// and default bus widths.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned INSTR_W_DEF = 9;
  localparam int unsigned CNT_W_DEF   = 8;

endpackage

// File: rtl/fetch_sequencer.sv
// NanoProcessor fetch/execute control: strobes the external PC counter, runs the
// imem req/ack handshake, holds IR and counts retired instructions.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               areset,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic [ADDR_W-1:0]  pc_data,
  output logic               pc_sload,
  output logic               pc_count_enable,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt,
  output logic               halted,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   retired
);

  state_t state_q;
  state_t state_d;
  logic   ir_load;
  logic   retire;

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes and the fetch request are decoded from the registered state, so an
  // async reset drops them immediately without waiting for an edge.
  always_comb begin
    state_d         = state_q;
    ir_load         = 1'b0;
    retire          = 1'b0;
    pc_sload        = 1'b0;
    pc_count_enable = 1'b0;
    pc_data         = '0;
    imem_req        = 1'b0;
    imem_addr       = '0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_value;
        if (imem_ack) begin
          pc_count_enable = 1'b1;
          ir_load         = 1'b1;
          state_d         = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          retire = 1'b1;
          if (halt) begin
            state_d = ST_HALT;
          end else begin
            if (jump) begin
              pc_sload = 1'b1;
              pc_data  = jump_target;
            end
            state_d = run ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (!run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      ir      <= '0;
      retired <= '0;
    end else begin
      if (ir_load) ir <= imem_rdata;
      if (retire)  retired <= retired + 1'b1;
    end
  end

  assign ir_valid = (state_q == ST_EXEC);
  assign halted   = (state_q == ST_HALT);
  assign state    = state_q;

endmodule
